// File: rtl/camera_pkg.sv
// Shared definitions for the camera stream generator and the capture side:
// sequencer states, test-pattern mode encodings and RGB565 colour constants.
package camera_pkg;

  // Frame sequencer states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_VSYNC  = 3'd1,
    ST_VBACK  = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_VFRONT = 3'd4
  } state_e;

  // Test-pattern modes as seen on the 2-bit mode input
  typedef enum logic [1:0] {
    MODE_BARS    = 2'd0,
    MODE_RAMP    = 2'd1,
    MODE_CHECKER = 2'd2,
    MODE_SOLID   = 2'd3
  } mode_e;

  // RGB565 colours used by the colour-bar pattern
  localparam logic [15:0] RGB_WHITE   = 16'hFFFF;
  localparam logic [15:0] RGB_YELLOW  = 16'hFFE0;
  localparam logic [15:0] RGB_CYAN    = 16'h07FF;
  localparam logic [15:0] RGB_GREEN   = 16'h07E0;
  localparam logic [15:0] RGB_MAGENTA = 16'hF81F;
  localparam logic [15:0] RGB_RED     = 16'hF800;
  localparam logic [15:0] RGB_BLUE    = 16'h001F;
  localparam logic [15:0] RGB_BLACK   = 16'h0000;

  // Coordinate widths on the pattern lookup interface
  localparam int unsigned PIX_X_W = 10;
  localparam int unsigned PIX_Y_W = 10;

  // Colour of bar idx, left to right
  function automatic logic [15:0] bar_color(input logic [2:0] idx);
    case (idx)
      3'd0: return RGB_WHITE;
      3'd1: return RGB_YELLOW;
      3'd2: return RGB_CYAN;
      3'd3: return RGB_GREEN;
      3'd4: return RGB_MAGENTA;
      3'd5: return RGB_RED;
      3'd6: return RGB_BLUE;
      default: return RGB_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/pattern_rom.sv
// Combinational test-pattern lookup: pixel coordinate + mode -> RGB565 pixel.
// Ports:
//   x, y   : pixel column / active line index
//   mode   : pattern selection (bars, ramp, checkerboard, solid)
//   solid  : colour used in solid mode
//   pixel  : resulting RGB565 value (registered by the caller)
module pattern_rom
  import camera_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 160
) (
  input  logic [PIX_X_W-1:0] x,
  input  logic [PIX_Y_W-1:0] y,
  input  mode_e              mode,
  input  logic [15:0]        solid,
  output logic [15:0]        pixel
);

  localparam int unsigned BAR_W = ((H_ACTIVE / 8) > 0) ? (H_ACTIVE / 8) : 1;

  logic [PIX_X_W-1:0] bar_idx;
  logic [2:0]         bar_sel;
  logic               unused_y;

  // Only the low line bits feed the patterns
  assign unused_y = ^y[PIX_Y_W-1:6];

  // Pattern selection; bar index clamps to the last bar for odd widths
  always_comb begin
    bar_idx = x / PIX_X_W'(BAR_W);
    bar_sel = (bar_idx > PIX_X_W'(7)) ? 3'd7 : bar_idx[2:0];
    pixel   = 16'h0000;
    case (mode)
      MODE_BARS:    pixel = bar_color(bar_sel);
      MODE_RAMP:    pixel = {x[4:0], y[5:0], x[4:0]};
      MODE_CHECKER: pixel = (x[3] ^ y[3]) ? 16'hFFFF : 16'h0000;
      default:      pixel = solid;
    endcase
  end

endmodule

// File: rtl/camera_stream_gen.sv
// Camera bus stand-in: emits RGB565 test frames on pclk/v_sync/h_ref/data_out.
// Ports:
//   clk_25, reset      : system clock, synchronous active-high reset
//   enable             : generate frames while high (frames never truncated)
//   mode, solid_color  : pattern selection, latched at the start of each frame
//   pclk               : pixel clock, clk_25/2, low in IDLE
//   v_sync, h_ref      : frame sync and byte-valid strobes
//   data_out           : pixel byte, high byte first, 0 outside h_ref
//   frame_done         : one-cycle pulse on the last cycle of each frame
module camera_stream_gen
  import camera_pkg::*;
#(
  parameter int unsigned H_ACTIVE    = 160,
  parameter int unsigned H_BLANK     = 40,
  parameter int unsigned V_ACTIVE    = 120,
  parameter int unsigned VSYNC_LINES = 3,
  parameter int unsigned V_BACK      = 17,
  parameter int unsigned V_FRONT     = 10
) (
  input  logic        clk_25,
  input  logic        reset,
  input  logic        enable,
  input  logic [1:0]  mode,
  input  logic [15:0] solid_color,
  output logic        pclk,
  output logic        v_sync,
  output logic        h_ref,
  output logic [7:0]  data_out,
  output logic        frame_done
);

  localparam int unsigned ACT_BYTES  = 2 * H_ACTIVE;
  localparam int unsigned LINE_BYTES = ACT_BYTES + H_BLANK;
  localparam int unsigned MAX_A      = (VSYNC_LINES > V_BACK) ? VSYNC_LINES : V_BACK;
  localparam int unsigned MAX_B      = (V_ACTIVE > V_FRONT) ? V_ACTIVE : V_FRONT;
  localparam int unsigned MAX_LINES  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned BW         = $clog2(LINE_BYTES);
  localparam int unsigned LW         = $clog2(MAX_LINES + 1);

  state_e        state;
  state_e        nxt_state;
  logic [BW-1:0] byte_cnt;
  logic [BW-1:0] nxt_byte;
  logic [LW-1:0] line_cnt;
  logic [LW-1:0] nxt_line;
  logic          last_byte;
  logic          last_line;
  logic          nxt_href;
  mode_e         mode_q;
  logic [15:0]   solid_q;
  logic [15:0]   nxt_pixel;
  logic [PIX_X_W-1:0] pix_x;
  logic [PIX_Y_W-1:0] pix_y;

  // Number of lines spent in each state
  function automatic logic [LW-1:0] state_lines(input state_e s);
    case (s)
      ST_VSYNC:  return LW'(VSYNC_LINES);
      ST_VBACK:  return LW'(V_BACK);
      ST_ACTIVE: return LW'(V_ACTIVE);
      ST_VFRONT: return LW'(V_FRONT);
      default:   return LW'(1);
    endcase
  endfunction

  // Position of the byte that follows the one currently on the bus
  always_comb begin
    last_byte = (byte_cnt == BW'(LINE_BYTES - 1));
    last_line = (line_cnt == state_lines(state) - LW'(1));
    nxt_state = state;
    nxt_byte  = byte_cnt + BW'(1);
    nxt_line  = line_cnt;
    if (last_byte) begin
      nxt_byte = '0;
      if (last_line) begin
        nxt_line = '0;
        case (state)
          ST_VSYNC:  nxt_state = ST_VBACK;
          ST_VBACK:  nxt_state = ST_ACTIVE;
          ST_ACTIVE: nxt_state = ST_VFRONT;
          ST_VFRONT: nxt_state = enable ? ST_VSYNC : ST_IDLE;
          default:   nxt_state = ST_IDLE;
        endcase
      end else begin
        nxt_line = line_cnt + LW'(1);
      end
    end
    nxt_href = (nxt_state == ST_ACTIVE) && (nxt_byte < BW'(ACT_BYTES));
    pix_x    = PIX_X_W'(nxt_byte >> 1);
    pix_y    = PIX_Y_W'(nxt_line);
  end

  pattern_rom #(
    .H_ACTIVE (H_ACTIVE)
  ) u_pattern_rom (
    .x     (pix_x),
    .y     (pix_y),
    .mode  (mode_q),
    .solid (solid_q),
    .pixel (nxt_pixel)
  );

  // Sequencer: bus outputs advance only on the pclk-low half of each byte
  always_ff @(posedge clk_25) begin
    if (reset) begin
      state      <= ST_IDLE;
      byte_cnt   <= '0;
      line_cnt   <= '0;
      mode_q     <= MODE_BARS;
      solid_q    <= 16'h0000;
      pclk       <= 1'b0;
      v_sync     <= 1'b0;
      h_ref      <= 1'b0;
      data_out   <= 8'h00;
      frame_done <= 1'b0;
    end else if (state == ST_IDLE) begin
      pclk       <= 1'b0;
      frame_done <= 1'b0;
      if (enable) begin
        state    <= ST_VSYNC;
        byte_cnt <= '0;
        line_cnt <= '0;
        mode_q   <= mode_e'(mode);
        solid_q  <= solid_color;
        v_sync   <= 1'b1;
        h_ref    <= 1'b0;
        data_out <= 8'h00;
      end
    end else if (!pclk) begin
      pclk       <= 1'b1;
      frame_done <= (state == ST_VFRONT) && last_byte && last_line;
    end else begin
      pclk       <= 1'b0;
      frame_done <= 1'b0;
      state      <= nxt_state;
      byte_cnt   <= nxt_byte;
      line_cnt   <= nxt_line;
      v_sync     <= (nxt_state == ST_VSYNC);
      h_ref      <= nxt_href;
      data_out   <= nxt_href ? (nxt_byte[0] ? nxt_pixel[7:0] : nxt_pixel[15:8]) : 8'h00;
      // Back-to-back frame: latch the pattern for the frame about to start
      if ((state == ST_VFRONT) && (nxt_state == ST_VSYNC)) begin
        mode_q  <= mode_e'(mode);
        solid_q <= solid_color;
      end
    end
  end

endmodule

// File: tb/tb_camera_stream_gen.sv
// Self-checking bench for camera_stream_gen using a reduced frame geometry.
module tb_camera_stream_gen;

  localparam int HA = 16;
  localparam int HB = 4;
  localparam int VA = 12;
  localparam int VS = 2;
  localparam int VB = 3;
  localparam int VF = 2;
  localparam int LINE = 2 * HA + HB;
  localparam int FRAME_LINES = VS + VB + VA + VF;
  localparam int FRAME_CLK = FRAME_LINES * LINE * 2;
  localparam int BAR_W = HA / 8;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [1:0]  mode;
  logic [15:0] solid_color;
  logic        pclk;
  logic        v_sync;
  logic        h_ref;
  logic [7:0]  data_out;
  logic        frame_done;

  camera_stream_gen #(
    .H_ACTIVE(HA), .H_BLANK(HB), .V_ACTIVE(VA),
    .VSYNC_LINES(VS), .V_BACK(VB), .V_FRONT(VF)
  ) dut (
    .clk_25(clk), .reset(reset), .enable(enable), .mode(mode),
    .solid_color(solid_color), .pclk(pclk), .v_sync(v_sync),
    .h_ref(h_ref), .data_out(data_out), .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int outs();
    return {19'd0, pclk, v_sync, h_ref, frame_done, data_out};
  endfunction

  // ---------------- behavioural reference model ----------------
  int bars[8] = '{'hFFFF, 'hFFE0, 'h07FF, 'h07E0, 'hF81F, 'hF800, 'h001F, 'h0000};

  function automatic int pix_of(input int md, input int sol, input int x, input int y);
    int bar;
    case (md)
      0: begin
        bar = x / BAR_W;
        if (bar > 7) bar = 7;
        return bars[bar];
      end
      1: return ((x % 32) << 11) | ((y % 64) << 5) | (x % 32);
      2: return ((((x >> 3) & 1) ^ ((y >> 3) & 1)) != 0) ? 'hFFFF : 0;
      default: return sol;
    endcase
  endfunction

  bit m_run = 0;
  int m_t = 0;
  int m_mode = 0;
  int m_solid = 0;

  // Model time: m_t counts clk cycles since the start of the current frame
  initial begin
    forever begin
      @(posedge clk);
      if (reset) m_run = 0;
      else if (!m_run) begin
        if (enable) begin
          m_run = 1; m_t = 0; m_mode = int'(mode); m_solid = int'(solid_color);
        end
      end else if (m_t == FRAME_CLK - 1) begin
        if (enable) begin
          m_t = 0; m_mode = int'(mode); m_solid = int'(solid_color);
        end else m_run = 0;
      end else m_t++;
    end
  end

  // Per-cycle comparison of all outputs against the model
  initial begin
    int byte_i, ln, b, e_pclk, e_vs, e_href, e_fd, e_data, p;
    @(posedge clk);
    forever begin
      @(negedge clk);
      e_pclk = 0; e_vs = 0; e_href = 0; e_fd = 0; e_data = 0;
      if (m_run) begin
        byte_i = m_t / 2;
        ln = byte_i / LINE;
        b = byte_i % LINE;
        e_pclk = m_t % 2;
        e_vs = (ln < VS) ? 1 : 0;
        e_fd = (m_t == FRAME_CLK - 1) ? 1 : 0;
        if (ln >= VS + VB && ln < VS + VB + VA && b < 2 * HA) begin
          e_href = 1;
          p = pix_of(m_mode, m_solid, b / 2, ln - VS - VB);
          e_data = (b % 2 == 1) ? (p & 'hFF) : ((p >> 8) & 'hFF);
        end
      end
      check("cycle_outputs", outs(),
            (e_pclk << 11) | (e_vs << 10) | (e_href << 9) | (e_fd << 8) | e_data);
    end
  end

  // ---------------- bus measurements for literal checks ----------------
  int cyc = 0, vs_run = 0, last_vs_len = 0, since_vs = 0, vs_to_href = -1;
  bit seen_href = 0, prev_vs = 0, prev_href = 0;
  int line_idx = 0, cur_len = 0, href_pulses = 0, len_min = 0, len_max = 0;
  int last_fd_cyc = 0, fd_interval = 0;
  int cap[VA][2*HA];

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (v_sync && !prev_vs) begin
        since_vs = 0; seen_href = 0; line_idx = 0; href_pulses = 0;
        len_min = 1 << 30; len_max = 0; vs_run = 0;
      end else since_vs++;
      if (v_sync) vs_run++;
      if (!v_sync && prev_vs) last_vs_len = vs_run;
      if (h_ref && !prev_href) begin
        if (!seen_href) begin vs_to_href = since_vs; seen_href = 1; end
        href_pulses++; cur_len = 0;
      end
      if (h_ref && pclk) begin
        if (line_idx < VA && cur_len < 2 * HA) cap[line_idx][cur_len] = int'(data_out);
        cur_len++;
      end
      if (!h_ref && prev_href) begin
        if (cur_len < len_min) len_min = cur_len;
        if (cur_len > len_max) len_max = cur_len;
        line_idx++;
      end
      if (frame_done) begin fd_interval = cyc - last_fd_cyc; last_fd_cyc = cyc; end
      prev_vs = v_sync; prev_href = h_ref;
    end
  end

  task automatic wait_fd(input string name);
    bit got = 0;
    for (int n = 0; n < FRAME_CLK + 200; n++) begin
      @(negedge clk); #1;
      if (frame_done) begin got = 1; break; end
    end
    check({"frame_done_", name}, int'(got), 1);
  endtask

  task automatic check_solid_frame(input string name, input int hi, input int lo);
    int bad = 0;
    for (int l = 0; l < VA; l++)
      for (int b = 0; b < 2 * HA; b++)
        if (cap[l][b] != ((b % 2 == 1) ? lo : hi)) bad++;
    check(name, bad, 0);
    check({name, "_lines"}, href_pulses, VA);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int bad;
    bit got;
    reset = 1'b1; enable = 1'b0; mode = 2'd0; solid_color = 16'h0000;
    repeat (3) @(negedge clk);
    #1 check("reset_outputs", outs(), 0);
    reset = 1'b0; enable = 1'b1; mode = 2'd0;

    // Frame 1: colour bars
    wait_fd("bars");
    check("vsync_len", last_vs_len, VS * LINE * 2);
    check("vsync_to_href", vs_to_href, (VS + VB) * LINE * 2);
    check("bars_byte0", cap[0][0], 'hFF);
    check("bars_byte1", cap[0][1], 'hFF);
    check("bars_pix2_hi", cap[0][4], 'hFF);
    check("bars_pix2_lo", cap[0][5], 'hE0);
    check("bars_last_lo", cap[0][31], 'h00);
    check("href_pulses", href_pulses, VA);
    check("href_len_min", len_min, 2 * HA);
    check("href_len_max", len_max, 2 * HA);
    mode = 2'd2;

    // Frame 2: checkerboard
    wait_fd("checker");
    check("chk_y0_x8_hi", cap[0][16], 'hFF);
    check("chk_y0_x8_lo", cap[0][17], 'hFF);
    check("chk_y8_x8_hi", cap[8][16], 'h00);
    check("chk_y8_x8_lo", cap[8][17], 'h00);
    check("frame_period", fd_interval, FRAME_CLK);
    mode = 2'd3; solid_color = 16'h1234;

    // Frame 3: solid, colour changed mid-frame must not show until next frame
    repeat (400) @(negedge clk);
    solid_color = 16'hABCD;
    wait_fd("solid1234");
    check_solid_frame("solid_1234", 'h12, 'h34);

    repeat (500) @(negedge clk);
    mode = 2'd1; solid_color = 16'h5555;
    wait_fd("solidABCD");
    check_solid_frame("solid_abcd", 'hAB, 'hCD);

    // Frame 5: ramp, x=5 y=3 -> 0x2865
    wait_fd("ramp");
    check("ramp_hi", cap[3][10], 'h28);
    check("ramp_lo", cap[3][11], 'h65);

    // Random patterns, with random mid-frame changes
    for (int f = 0; f < 3; f++) begin
      mode = 2'($urandom_range(0, 3)); solid_color = 16'($urandom);
      repeat ($urandom_range(100, 900)) @(negedge clk);
      mode = 2'($urandom_range(0, 3)); solid_color = 16'($urandom);
      wait_fd("random");
    end

    // Drop enable mid-frame: the frame must complete, then stay idle
    got = 0;
    for (int n = 0; n < 2 * FRAME_CLK; n++) begin
      @(negedge clk); #1;
      if (line_idx == VA / 2) begin got = 1; break; end
    end
    check("reach_mid_frame", int'(got), 1);
    enable = 1'b0;
    wait_fd("after_drop");
    bad = 0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk); #1;
      if (pclk || v_sync || h_ref) bad++;
    end
    check("idle_after_drop", bad, 0);

    // Restart, then reset during ACTIVE
    enable = 1'b1; mode = 2'd0;
    got = 0;
    for (int n = 0; n < FRAME_CLK; n++) begin
      @(negedge clk); #1;
      if (h_ref) begin got = 1; break; end
    end
    check("restart_href", int'(got), 1);
    repeat (20) @(negedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    #1 check("reset_mid_active", outs(), 0);
    reset = 1'b0;
    wait_fd("after_reset");
    check("vsync_len_after_reset", last_vs_len, VS * LINE * 2);
    check("vsync_to_href_after_reset", vs_to_href, (VS + VB) * LINE * 2);
    check("bars_after_reset", cap[0][5], 'hE0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
